// File: rtl/instr_fetch_pkg.sv
// Shared widths, reset/NOP values and HLT opcode decoding for the instruction-fetch stage.
package instr_fetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 16'h0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  localparam int         OPC_LSB    = 12;
  localparam int         OPC_W      = 4;
  localparam logic [3:0] HLT_OPCODE = 4'hF;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
    return word[OPC_LSB +: OPC_W] == HLT_OPCODE;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: pipeline control in, IM read port, and the decode-facing instruction/PC outputs.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  logic [ADDR_W-1:0]  im_addr;
  logic               im_rd_en;
  logic [INSTR_W-1:0] im_instr;

  logic [INSTR_W-1:0] instr;
  logic               instr_vld;
  logic [ADDR_W-1:0]  pc_out;
  logic [ADDR_W-1:0]  pc_plus1;
  logic               halted;

  modport master (
    input  stall, redirect, redirect_pc, im_instr,
    output im_addr, im_rd_en, instr, instr_vld, pc_out, pc_plus1, halted
  );

  modport slave (
    output stall, redirect, redirect_pc, im_instr,
    input  im_addr, im_rd_en, instr, instr_vld, pc_out, pc_plus1, halted
  );

endinterface

// File: rtl/instr_fetch_pc_gen.sv
// Program counter: synchronous reset, redirect load, and a wrapping +1 advance.
module instr_fetch_pc_gen
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);

  // A redirect target always beats the increment, even when the stage is otherwise holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (advance) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: issues pc to the IM and pairs each registered IM result with its address.
// Optional halt-on-HLT behaviour is compiled in when IF_HALT_EN is defined.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  instr_fetch_if.master   bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] f_pc;
  logic              f_vld;
  logic              halted;
  logic              hlt_take;
  logic              redirect_take;
  logic              advance;

`ifdef IF_HALT_EN
  fetch_state_e state_q;
  fetch_state_e state_d;

  assign hlt_take = f_vld & ~bus.stall & ~bus.redirect & is_hlt(bus.im_instr);
  assign halted   = (state_q == FETCH_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt is sticky: only reset leaves FETCH_HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_RUN:  if (hlt_take) state_d = FETCH_HALT;
      FETCH_HALT: state_d = FETCH_HALT;
      default:    state_d = FETCH_RUN;
    endcase
  end
`else
  assign hlt_take = 1'b0;
  assign halted   = 1'b0;
`endif

  assign redirect_take = bus.redirect & ~halted;
  assign advance       = ~bus.stall & ~halted & ~hlt_take;

  instr_fetch_pc_gen u_pc_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect_take),
    .advance (advance),
    .load_pc (bus.redirect_pc),
    .pc      (pc)
  );

  // f_pc is left alone when a fetch is killed; it only matters while f_vld is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_vld <= 1'b0;
      f_pc  <= RESET_PC;
    end else if (redirect_take || halted || hlt_take) begin
      f_vld <= 1'b0;
    end else if (!bus.stall) begin
      f_vld <= 1'b1;
      f_pc  <= pc;
    end
  end

  assign bus.im_addr   = pc;
  assign bus.im_rd_en  = ~rst & ~bus.stall & ~halted;
  assign bus.instr     = f_vld ? bus.im_instr : NOP_INSTR;
  assign bus.instr_vld = f_vld;
  assign bus.pc_out    = f_pc;
  assign bus.pc_plus1  = f_pc + ADDR_W'(1);
  assign bus.halted    = halted;

endmodule
